// File: rtl/sha1_wb_host.sv
// Wishbone master that runs one 512-bit block through a memory-mapped SHA1 peripheral:
// ID check, arm, message load, DONE poll, digest readback.
module sha1_wb_host #(
   parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
   parameter int          ACK_TIMEOUT  = 16,
   parameter int          POLL_MAX     = 255
) (
   input  logic         wb_clk_i,
   input  logic         reset,
   input  logic         start,
   input  logic [511:0] msg_i,
   output logic         busy,
   output logic         done_o,
   output logic [159:0] digest_o,
   output logic [1:0]   err_o,
   output logic         wbm_cyc_o,
   output logic         wbm_stb_o,
   output logic         wbm_we_o,
   output logic [3:0]   wbm_sel_o,
   output logic [31:0]  wbm_adr_o,
   output logic [31:0]  wbm_dat_o,
   input  logic         wbm_ack_i,
   input  logic [31:0]  wbm_dat_i
);

   localparam logic [31:0] ID_VALUE = 32'h53484131;
   localparam logic [31:0] ADR_ID   = BASE_ADDRESS + 32'h4;
   localparam logic [31:0] ADR_OPS  = BASE_ADDRESS + 32'h8;
   localparam logic [31:0] ADR_MSG  = BASE_ADDRESS + 32'hC;
   localparam logic [31:0] ADR_DIG  = BASE_ADDRESS + 32'h10;
   localparam int          ACK_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [7:0]  POLL_LAST = 8'(POLL_MAX);

   localparam logic [1:0] ERR_OK   = 2'd0;
   localparam logic [1:0] ERR_ID   = 2'd1;
   localparam logic [1:0] ERR_ACK  = 2'd2;
   localparam logic [1:0] ERR_POLL = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_CHK_ID, S_ARM, S_LOAD, S_POLL, S_READ, S_FINISH
   } state_t;

   // Each access walks STB (one strobe cycle) -> WAIT (cyc held) -> GAP (cyc low).
   typedef enum logic [1:0] {PH_STB, PH_WAIT, PH_GAP} phase_t;

   state_t state, state_n;
   phase_t phase, phase_n;

   logic [15:0][31:0] msg_q;
   logic [4:0][31:0]  dig_q;
   logic [3:0]        word_cnt;
   logic [2:0]        dig_cnt;
   logic [7:0]        poll_cnt;
   logic [ACK_W-1:0]  ack_cnt;
   logic [1:0]        err_q;

   logic access, ack_ok, timeout;

   assign access    = (state != S_IDLE) && (state != S_FINISH);
   assign wbm_cyc_o = access && (phase != PH_GAP);
   assign wbm_stb_o = access && (phase == PH_STB);
   assign ack_ok    = wbm_cyc_o && wbm_ack_i;
   assign timeout   = access && (phase == PH_WAIT) && !wbm_ack_i && (ack_cnt == ACK_LAST);

   assign busy     = access;
   assign done_o   = (state == S_FINISH);
   assign err_o    = err_q;
   assign digest_o = dig_q;

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         state <= S_IDLE;
         phase <= PH_STB;
      end else begin
         state <= state_n;
         phase <= phase_n;
      end
   end

   always_comb begin
      state_n = state;
      phase_n = phase;
      case (state)
         S_IDLE: begin
            phase_n = PH_STB;
            if (start) state_n = S_CHK_ID;
         end
         S_FINISH: begin
            phase_n = PH_STB;
            state_n = S_IDLE;
         end
         default: begin
            if (phase == PH_GAP) begin
               phase_n = PH_STB;
            end else if (ack_ok) begin
               phase_n = PH_GAP;
               case (state)
                  S_CHK_ID: state_n = (wbm_dat_i == ID_VALUE) ? S_ARM : S_FINISH;
                  S_ARM:    state_n = S_LOAD;
                  S_LOAD:   if (word_cnt == 4'd15) state_n = S_POLL;
                  S_POLL: begin
                     if (wbm_dat_i[3])                state_n = S_READ;
                     else if (poll_cnt == POLL_LAST)  state_n = S_FINISH;
                  end
                  S_READ:   if (dig_cnt == 3'd4) state_n = S_FINISH;
                  default: ;
               endcase
            end else if (timeout) begin
               state_n = S_FINISH;
            end else if (phase == PH_STB) begin
               phase_n = PH_WAIT;
            end
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         msg_q    <= '0;
         dig_q    <= '0;
         word_cnt <= '0;
         dig_cnt  <= '0;
         poll_cnt <= '0;
         ack_cnt  <= '0;
         err_q    <= ERR_OK;
      end else begin
         // Counts wait cycles only; reloads on every strobe.
         if (phase == PH_WAIT) begin
            if (ack_cnt != ACK_LAST) ack_cnt <= ack_cnt + ACK_W'(1);
         end else begin
            ack_cnt <= '0;
         end

         case (state)
            S_IDLE: if (start) begin
               msg_q    <= msg_i;
               err_q    <= ERR_OK;
               word_cnt <= '0;
               dig_cnt  <= '0;
               poll_cnt <= '0;
            end
            S_CHK_ID: if (ack_ok && (wbm_dat_i != ID_VALUE)) err_q <= ERR_ID;
            S_LOAD:   if (ack_ok && (word_cnt != 4'd15)) word_cnt <= word_cnt + 4'd1;
            S_POLL: if (ack_ok && !wbm_dat_i[3]) begin
               if (poll_cnt == POLL_LAST) err_q <= ERR_POLL;
               else                       poll_cnt <= poll_cnt + 8'd1;
            end
            S_READ: if (ack_ok) begin
               dig_q[dig_cnt] <= wbm_dat_i;
               if (dig_cnt != 3'd4) dig_cnt <= dig_cnt + 3'd1;
            end
            default: ;
         endcase

         if (timeout) err_q <= ERR_ACK;
      end
   end

   always_comb begin
      wbm_adr_o = '0;
      wbm_we_o  = 1'b0;
      wbm_dat_o = '0;
      wbm_sel_o = '0;
      if (wbm_cyc_o) begin
         wbm_sel_o = 4'hF;
         case (state)
            S_CHK_ID: wbm_adr_o = ADR_ID;
            S_ARM: begin
               wbm_adr_o = ADR_OPS;
               wbm_we_o  = 1'b1;
               wbm_dat_o = 32'h1;
            end
            S_LOAD: begin
               wbm_adr_o = ADR_MSG;
               wbm_we_o  = 1'b1;
               wbm_dat_o = msg_q[word_cnt];
            end
            S_POLL:   wbm_adr_o = ADR_OPS;
            S_READ:   wbm_adr_o = ADR_DIG;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha1_wb_host.sv
// Scoreboarded bench for sha1_wb_host against a behavioural SHA1 peripheral model.
module tb_sha1_wb_host;

   localparam logic [31:0]  BASE    = 32'h30000024;
   localparam logic [31:0]  ADR_ID  = BASE + 32'h4;
   localparam logic [31:0]  ADR_OPS = BASE + 32'h8;
   localparam logic [31:0]  ADR_MSG = BASE + 32'hC;
   localparam logic [31:0]  ADR_DIG = BASE + 32'h10;
   localparam int           ACK_TO  = 16;
   localparam int           PMAX    = 4;
   localparam logic [159:0] DIG_ABC = {32'h9cd0d89d, 32'h7850c26c, 32'hba3e2571,
                                       32'h4706816a, 32'ha9993e36};
   localparam logic [511:0] MSG_ABC = {32'h00000018, 448'h0, 32'h61626380};

   logic         wb_clk_i = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [511:0] msg_i = '0;
   logic         busy, done_o;
   logic [159:0] digest_o;
   logic [1:0]   err_o;
   logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]   wbm_sel_o;
   logic [31:0]  wbm_adr_o, wbm_dat_o;
   logic         wbm_ack_i = 1'b0;
   logic [31:0]  wbm_dat_i = '0;

   sha1_wb_host #(.BASE_ADDRESS(BASE), .ACK_TIMEOUT(ACK_TO), .POLL_MAX(PMAX)) dut (
      .wb_clk_i(wb_clk_i), .reset(reset), .start(start), .msg_i(msg_i),
      .busy(busy), .done_o(done_o), .digest_o(digest_o), .err_o(err_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct packed {logic we; logic [31:0] adr; logic [31:0] dat;} acc_t;
   typedef struct packed {logic [1:0] err; logic [159:0] dig;} res_t;

   acc_t exp_acc[$];
   res_t exp_res[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s", nm);
   endtask

   function automatic logic [159:0] sha1_blk(input logic [15:0][31:0] blk);
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, t;
      for (int i = 0; i < 16; i++) w[i] = blk[i];
      for (int i = 16; i < 80; i++) begin
         t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
         w[i] = {t[30:0], t[31]};
      end
      a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
      for (int i = 0; i < 80; i++) begin
         if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
         else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
         else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
         else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
         t = {a[26:0], a[31:27]} + f + e + k + w[i];
         e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
      end
      return {e + 32'hC3D2E1F0, d + 32'h10325476, c + 32'h98BADCFE,
              b + 32'hEFCDAB89, a + 32'h67452301};
   endfunction

   // Peripheral model knobs and state
   bit                bad_id = 0;
   int                stall_idx = -1;
   int                done_after = 3;
   int                ack_lat = 0;
   logic [15:0][31:0] blk = '0;
   logic [4:0][31:0]  dg = '0;
   int                msg_idx = 0, dig_idx = 0, poll_n = 0, cur_idx = 0;
   bit                pend = 0;
   int                lat_left = 0;
   logic [31:0]       rdata = '0;
   bit                w9_acked = 0;
   int                cyc_n = 0, stall_at = 0, last_cyc_hi = 0;

   always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

   initial begin
      forever begin
         @(negedge wb_clk_i);
         wbm_ack_i = 1'b0;
         if (reset) begin
            pend = 0;
         end else if (wbm_stb_o) begin
            pend = 1; lat_left = ack_lat; rdata = '0;
            if (wbm_adr_o == ADR_ID) begin
               rdata = bad_id ? 32'hf00df00d : 32'h53484131;
            end else if (wbm_adr_o == ADR_OPS) begin
               if (wbm_we_o) begin
                  msg_idx = 0; dig_idx = 0; poll_n = 0;
               end else begin
                  poll_n++;
                  rdata = (poll_n > done_after && msg_idx == 16) ? 32'h8 : 32'h0;
               end
            end else if (wbm_adr_o == ADR_MSG) begin
               if (msg_idx == stall_idx) begin pend = 0; stall_at = cyc_n; end
               if (msg_idx < 16) blk[msg_idx] = wbm_dat_o;
               cur_idx = msg_idx;
               msg_idx++;
            end else if (wbm_adr_o == ADR_DIG) begin
               if (dig_idx == 0) dg = sha1_blk(blk);
               rdata = (dig_idx < 5) ? dg[dig_idx] : 32'h0;
               dig_idx++;
            end
         end else if (pend) begin
            if (lat_left == 0) begin
               wbm_ack_i = 1'b1;
               wbm_dat_i = rdata;
               pend = 0;
               if (wbm_adr_o == ADR_MSG && cur_idx == 9) w9_acked = 1;
            end else begin
               lat_left--;
            end
         end
      end
   end

   // Monitor: pops expected accesses on every strobe, expected results on every done_o.
   acc_t a_exp;
   res_t r_exp;
   bit   prev_stb = 0;
   initial begin
      forever begin
         @(negedge wb_clk_i);
         if (!reset && wbm_stb_o) begin
            chk("stb_single_cycle", prev_stb, 1'b0);
            chk("sel_during_stb", wbm_sel_o, 4'hF);
            if (exp_acc.size() == 0) begin
               fail("unexpected_access");
            end else begin
               a_exp = exp_acc.pop_front();
               chk("acc_we", wbm_we_o, a_exp.we);
               chk("acc_adr", wbm_adr_o, a_exp.adr);
               if (a_exp.we) chk("acc_dat", wbm_dat_o, a_exp.dat);
            end
         end
         if (!reset && done_o) begin
            if (exp_res.size() == 0) begin
               fail("unexpected_done");
            end else begin
               r_exp = exp_res.pop_front();
               chk("err_o", err_o, r_exp.err);
               chk("digest_o", digest_o, r_exp.dig);
               chk("busy_at_done", busy, 1'b0);
            end
         end
         if (wbm_cyc_o) last_cyc_hi = cyc_n;
         prev_stb = wbm_stb_o;
      end
   end

   task automatic push_acc(input logic we, input logic [31:0] adr, input logic [31:0] dat);
      acc_t x;
      x.we = we; x.adr = adr; x.dat = dat;
      exp_acc.push_back(x);
   endtask

   task automatic push_job(input bit id_ok, input int n_msg, input int n_poll, input bit reads,
                           input logic [1:0] err, input logic [159:0] dig);
      res_t x;
      logic [511:0] m;
      m = MSG_ABC;
      push_acc(1'b0, ADR_ID, '0);
      if (id_ok) begin
         push_acc(1'b1, ADR_OPS, 32'h1);
         for (int i = 0; i < n_msg; i++) push_acc(1'b1, ADR_MSG, m[32*i +: 32]);
         for (int i = 0; i < n_poll; i++) push_acc(1'b0, ADR_OPS, '0);
         if (reads) for (int i = 0; i < 5; i++) push_acc(1'b0, ADR_DIG, '0);
      end
      x.err = err; x.dig = dig;
      exp_res.push_back(x);
   endtask

   task automatic kick();
      @(posedge wb_clk_i); #1;
      msg_i = MSG_ABC; start = 1'b1;
      @(posedge wb_clk_i); #1;
      start = 1'b0; msg_i = ~MSG_ABC;
      chk("busy_after_start", busy, 1'b1);
   endtask

   task automatic do_job(input bit poke);
      kick();
      for (int i = 0; i < 3000 && exp_res.size() != 0; i++) begin
         @(negedge wb_clk_i);
         start = poke && busy && (i % 13 == 4);
         if (start) msg_i = {16{$urandom}};
      end
      start = 1'b0;
      if (exp_res.size() != 0) fail("job_never_finished");
      chk("accesses_left_over", exp_acc.size(), 0);
      repeat (4) @(negedge wb_clk_i);
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_cyc"}, wbm_cyc_o, 1'b0);
      chk({tag, "_stb"}, wbm_stb_o, 1'b0);
      chk({tag, "_we"}, wbm_we_o, 1'b0);
      chk({tag, "_sel"}, wbm_sel_o, 4'h0);
      chk({tag, "_adr"}, wbm_adr_o, 32'h0);
      chk({tag, "_dat"}, wbm_dat_o, 32'h0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done_o, 1'b0);
      chk({tag, "_err"}, err_o, 2'd0);
      chk({tag, "_digest"}, digest_o, 160'h0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog_expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge wb_clk_i);
      #1 check_reset_outs("por");
      reset = 1'b0;
      repeat (3) @(posedge wb_clk_i);

      // happy path, with start pokes while busy
      push_job(1, 16, 4, 1, 2'd0, DIG_ABC);
      do_job(1);

      // bad ID, slow acks; digest keeps previous value
      bad_id = 1; ack_lat = 2;
      push_job(0, 0, 0, 0, 2'd1, DIG_ABC);
      do_job(1);
      bad_id = 0;

      // 7th message write never acked
      ack_lat = 1; stall_idx = 6;
      push_job(1, 7, 0, 0, 2'd2, DIG_ABC);
      do_job(0);
      chk("cyc_cycles_after_stalled_stb", last_cyc_hi - stall_at, ACK_TO);
      stall_idx = -1;

      // DONE never set: POLL_MAX+1 status reads then give up
      ack_lat = 0; done_after = 1000;
      push_job(1, 16, PMAX + 1, 0, 2'd3, DIG_ABC);
      do_job(1);
      done_after = 3;

      // reset right after the ack of message word 9
      w9_acked = 0;
      push_job(1, 16, 4, 1, 2'd0, DIG_ABC);
      kick();
      for (int i = 0; i < 2000 && !w9_acked; i++) begin
         @(posedge wb_clk_i); #1;
      end
      if (!w9_acked) fail("word9_ack_not_seen");
      reset = 1'b1;
      @(posedge wb_clk_i); #1;
      check_reset_outs("mid_load");
      exp_acc.delete();
      exp_res.delete();
      @(posedge wb_clk_i); #1;
      reset = 1'b0;
      repeat (6) @(posedge wb_clk_i);

      push_job(1, 16, 4, 1, 2'd0, DIG_ABC);
      do_job(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sha1_wb_host.md
SHA1_WB_HOST -- requirements
Module: sha1_wb_host

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h30000024, the SHA1 peripheral register base.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, the maximum cycles to wait for wbm_ack_i per access.
REQ-003 SHALL have parameter POLL_MAX, default 255, the maximum OPS status reads before giving up.
REQ-004 Clock is wb_clk_i; reset is reset, synchronous, active-high.
REQ-005 Ports, in order:
  - wb_clk_i  in  1  clock
  - reset  in  1  sync active-high reset
  - start  in  1  begin a hash job; sampled in IDLE only
  - msg_i  in  512  message block; word i = msg_i[32i+31:32i]
  - busy  out  1  job in progress
  - done_o  out  1  one-cycle pulse at job end, success or error
  - digest_o  out  160  result; word k = digest_o[32k+31:32k]
  - err_o  out  2  0=ok, 1=bad ID, 2=ack timeout, 3=poll limit
  - wbm_cyc_o  out  1  bus cycle
  - wbm_stb_o  out  1  strobe
  - wbm_we_o  out  1  write enable
  - wbm_sel_o  out  4  byte selects, always 4'hF during access
  - wbm_adr_o  out  32  address
  - wbm_dat_o  out  32  write data
  - wbm_ack_i  in  1  peripheral acknowledge
  - wbm_dat_i  in  32  read data, valid when wbm_ack_i=1

Function
REQ-006 Bus access: drive adr/we/dat/sel with cyc=1, stb=1 for exactly one cycle; hold cyc=1, stb=0 until ack. On ack, capture wbm_dat_i; next cycle cyc=0 (minimum one idle cycle between accesses).
REQ-007 Ack wait counter starts at the cycle after the strobe. If ack has not arrived after ACK_TIMEOUT cycles: drop cyc, err_o=2, go to FINISH.
REQ-008 An ack arriving while cyc=0 SHALL be ignored.
REQ-009 States: IDLE, CHK_ID, ARM, LOAD, POLL, READ, FINISH.
REQ-010 IDLE: busy=0, bus idle. On start=1, latch msg_i into an internal register, clear err_o, set busy=1, go to CHK_ID.
REQ-011 CHK_ID: read BASE+4. If data != 32'h53484131, err_o=1 and go to FINISH; otherwise go to ARM.
REQ-012 ARM: write BASE+8 with data 32'h1. This resets the peripheral's message and digest indices.
REQ-013 LOAD: 16 writes to BASE+'hC, words 0..15 of the latched message in order. The 4-bit word counter advances on each ack. After the ack of word 15, go to POLL.
REQ-014 POLL: read BASE+8. If bit3 (DONE)=1, go to READ. Otherwise increment the 8-bit poll counter and repeat. A poll that returns DONE=0 with the counter at POLL_MAX sets err_o=3 and goes to FINISH.
REQ-015 READ: 5 reads of BASE+'h10. The k-th ack data goes to digest_o word k (k=0..4). After the 5th ack, go to FINISH.
REQ-016 digest_o SHALL change only in READ and SHALL hold its value otherwise, including on error.
REQ-017 FINISH: done_o=1 for one cycle, busy=0, go to IDLE. err_o holds until the next accepted start.
REQ-018 start while busy=1 SHALL be ignored; msg_i changes after acceptance SHALL not affect the job.
REQ-019 All counters SHALL wrap-protect: the word counter stops at 15, the digest counter at 4, the poll counter saturates at POLL_MAX.

Reset
REQ-020 reset=1 at any clock edge, including mid-access, SHALL force: state=IDLE, cyc=stb=we=0, sel=0, adr=0, dat_o=0, busy=0, done_o=0, err_o=0, digest_o=0, all counters 0.
REQ-021 The first access after reset release SHALL be a new CHK_ID, and only after start.

Verification
REQ-022 Happy path: peripheral model computes SHA1 of "abc" padded block, DONE after 3 polls -> 1 ID read, 1 OPS write of 32'h1, 16 MSG writes, 4 OPS reads, 5 digest reads; digest_o = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d (word order per model); done_o pulse; err_o=0.
REQ-023 Bad ID: model returns 32'hf00df00d at BASE+4 -> no further accesses, done_o pulse, err_o=1, digest_o unchanged.
REQ-024 Ack timeout: model never acks the 7th MSG write -> cyc drops 16 cycles after that strobe; err_o=2; done_o pulse.
REQ-025 Poll limit: DONE never set, POLL_MAX=4 -> exactly 5 OPS reads, then err_o=3; no digest reads.
REQ-026 Reset mid-LOAD (after word 9 ack) -> next cycle all outputs at reset values; a new start runs the full sequence from CHK_ID.
REQ-027 Protocol checks: stb never high for more than 1 consecutive cycle; sel=4'hF whenever stb=1; start pulses during busy produce no extra jobs.
